// File: rtl/lfsr_checker_if.sv
// Stream-side bundle of the PRBS checker: restart/data inputs plus lock and error status.
// The master drives the received stream; the slave is the checker itself.
interface lfsr_checker_if #(
    parameter int CNT_W = 16
);
    logic             clear;
    logic             in_valid;
    logic             in_bit;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;

    modport master (
        output clear, in_valid, in_bit,
        input  locked, err_pulse, err_count, bit_count
    );

    modport slave (
        input  clear, in_valid, in_bit,
        output locked, err_pulse, err_count, bit_count
    );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising serial PRBS checker for the Fibonacci LFSR generator stream.
// Seeds a local predictor from received bits, locks after a run of matches, then counts errors.
module lfsr_checker #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_THR = 4,
    parameter int CNT_W    = 16
) (
    input  logic          clk,
    input  logic          reset,
    lfsr_checker_if.slave bus
);

    localparam logic [7:0] TAPS_ALL =
        (N == 2) ? 8'b0000_0011 :
        (N == 3) ? 8'b0000_0110 :
        (N == 4) ? 8'b0000_1100 :
        (N == 5) ? 8'b0001_0100 :
        (N == 6) ? 8'b0011_0000 :
        (N == 7) ? 8'b0110_0000 :
                   8'b1011_1000;
    localparam logic [N-1:0]     TAPS      = TAPS_ALL[N-1:0];
    localparam logic [3:0]       SEED_LAST = 4'(N - 1);
    localparam logic [7:0]       LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [7:0]       LOSS_LAST = 8'(LOSS_THR - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        SEED,
        VERIFY,
        LOCKED
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] p;
    logic [3:0]   seed_cnt;
    logic [7:0]   match_cnt;
    logic [7:0]   miss_cnt;

    logic predicted;
    logic bit_match;
    logic p_nonzero;
    logic seed_done;
    logic lock_hit;
    logic loss_hit;

    // An all-zero predictor is a fixed point of the LFSR, so it must never count as a match.
    always_comb begin
        predicted = ^(p & TAPS);
        bit_match = (bus.in_bit == predicted);
        p_nonzero = |p;
        seed_done = (seed_cnt == SEED_LAST);
        lock_hit  = bit_match && p_nonzero && (match_cnt == LOCK_LAST);
        loss_hit  = !bit_match && (miss_cnt == LOSS_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SEED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.clear) begin
            state_next = SEED;
        end else if (bus.in_valid) begin
            case (state)
                SEED:    if (seed_done) state_next = VERIFY;
                VERIFY:  if (lock_hit)  state_next = LOCKED;
                LOCKED:  if (loss_hit)  state_next = SEED;
                default: state_next = SEED;
            endcase
        end
    end

    always_comb begin
        bus.locked = (state == LOCKED);
    end

    // Once locked the predictor free-runs on its own output, so a channel error costs one mismatch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p             <= '0;
            seed_cnt      <= '0;
            match_cnt     <= '0;
            miss_cnt      <= '0;
            bus.err_pulse <= 1'b0;
            bus.err_count <= '0;
            bus.bit_count <= '0;
        end else if (bus.clear) begin
            p             <= '0;
            seed_cnt      <= '0;
            match_cnt     <= '0;
            miss_cnt      <= '0;
            bus.err_pulse <= 1'b0;
            bus.err_count <= '0;
            bus.bit_count <= '0;
        end else begin
            bus.err_pulse <= 1'b0;
            if (bus.in_valid) begin
                case (state)
                    SEED: begin
                        p <= {p[N-2:0], bus.in_bit};
                        if (seed_done) begin
                            seed_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            seed_cnt <= seed_cnt + 4'd1;
                        end
                    end
                    VERIFY: begin
                        p <= {p[N-2:0], bus.in_bit};
                        if (bit_match && p_nonzero) begin
                            if (lock_hit) begin
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                match_cnt <= match_cnt + 8'd1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        p <= {p[N-2:0], predicted};
                        if (bus.bit_count != CNT_MAX) begin
                            bus.bit_count <= bus.bit_count + CNT_ONE;
                        end
                        if (!bit_match) begin
                            bus.err_pulse <= 1'b1;
                            if (bus.err_count != CNT_MAX) begin
                                bus.err_count <= bus.err_count + CNT_ONE;
                            end
                            if (loss_hit) begin
                                miss_cnt <= '0;
                                seed_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 8'd1;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        p <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a 16-bit and a 4-bit counter instance run on the same stream.
// Expected outputs are queued as each cycle is driven and popped after the sampling edge.
module tb_lfsr_checker;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lfsr_checker_if #(.CNT_W(16)) bus ();
    lfsr_checker_if #(.CNT_W(4))  bus_s ();

    lfsr_checker #(.N(4), .LOCK_CNT(8), .LOSS_THR(4), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    lfsr_checker #(.N(4), .LOCK_CNT(8), .LOSS_THR(4), .CNT_W(4)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    typedef struct packed {
        logic        locked;
        logic        pulse;
        logic [15:0] err;
        logic [15:0] bits;
        logic        locked_s;
        logic        pulse_s;
        logic [3:0]  err_s;
        logic [3:0]  bits_s;
    } obs_t;

    bit   stream_bits [15] = '{0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 1};
    obs_t sb [$];
    obs_t got;
    obs_t exp;
    int   vectors     = 0;
    int   miscompares = 0;

    // Behavioural model of the checker with unbounded counts; saturation is applied on readout.
    int         m_state;
    logic [3:0] m_p;
    int         m_seed;
    int         m_match;
    int         m_miss;
    int         m_err;
    int         m_bits;
    logic       m_pulse;

    function automatic void model_clear();
        m_state = 0; m_p = 4'b0000; m_seed = 0; m_match = 0; m_miss = 0;
        m_err = 0; m_bits = 0; m_pulse = 1'b0;
    endfunction

    function automatic void model_step(input logic v, input logic b, input logic c);
        logic pred;
        m_pulse = 1'b0;
        if (c) begin
            model_clear();
        end else if (v) begin
            pred = m_p[3] ^ m_p[2];
            if (m_state == 0) begin
                m_p = {m_p[2:0], b};
                m_seed++;
                if (m_seed == 4) begin
                    m_state = 1; m_seed = 0; m_match = 0;
                end
            end else if (m_state == 1) begin
                if (b == pred && m_p != 4'b0000) m_match++;
                else m_match = 0;
                m_p = {m_p[2:0], b};
                if (m_match == 8) begin
                    m_state = 2; m_match = 0; m_miss = 0;
                end
            end else begin
                m_bits++;
                m_p = {m_p[2:0], pred};
                if (b != pred) begin
                    m_err++; m_pulse = 1'b1; m_miss++;
                    if (m_miss == 4) begin
                        m_state = 0; m_seed = 0; m_miss = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
        end
    endfunction

    function automatic obs_t model_expect();
        obs_t o;
        o.locked   = (m_state == 2);
        o.pulse    = m_pulse;
        o.err      = (m_err  > 65535) ? 16'hFFFF : 16'(m_err);
        o.bits     = (m_bits > 65535) ? 16'hFFFF : 16'(m_bits);
        o.locked_s = (m_state == 2);
        o.pulse_s  = m_pulse;
        o.err_s    = (m_err  > 15) ? 4'hF : 4'(m_err);
        o.bits_s   = (m_bits > 15) ? 4'hF : 4'(m_bits);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.locked   = bus.locked;
        o.pulse    = bus.err_pulse;
        o.err      = bus.err_count;
        o.bits     = bus.bit_count;
        o.locked_s = bus_s.locked;
        o.pulse_s  = bus_s.err_pulse;
        o.err_s    = bus_s.err_count;
        o.bits_s   = bus_s.bit_count;
        return o;
    endfunction

    task automatic drive(input logic v, input logic b, input logic c);
        @(negedge clk);
        bus.in_valid   = v; bus.in_bit   = b; bus.clear   = c;
        bus_s.in_valid = v; bus_s.in_bit = b; bus_s.clear = c;
        model_step(v, b, c);
        sb.push_back(model_expect());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.clear = 1'b0;
        bus_s.in_valid = 1'b0; bus_s.in_bit = 1'b0; bus_s.clear = 1'b0;
        reset = 1'b0;
        model_clear();
        #12;
        got = sample();
        vectors++;
        if (got !== obs_t'(0)) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got %h expected 0", got);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'($urandom_range(1)), 1'b0);
            exp = sb.pop_front(); got = sample(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL reset_idle cycle %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_lock_clean();
        int lock_at = -1;
        drive(1'b0, 1'b0, 1'b1);
        exp = sb.pop_front(); got = sample(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL clean_clear: got %h expected %h", got, exp);
        end
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, stream_bits[i % 15], 1'b0);
            exp = sb.pop_front(); got = sample(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL clean_stream bit %0d: got %h expected %h", i, got, exp);
            end
            if (lock_at < 0 && got.locked) lock_at = i + 1;
        end
        vectors++;
        if (lock_at != 12) begin
            miscompares++;
            $display("[TB] FAIL clean_lock_point: locked after bit %0d, expected 12", lock_at);
        end
        vectors++;
        if (got.err !== 16'd0 || got.bits !== 16'd28) begin
            miscompares++;
            $display("[TB] FAIL clean_counts: err %0d bits %0d, expected 0 and 28", got.err, got.bits);
        end
    endtask

    task automatic test_gapped();
        int lock_at = -1;
        int nvalid  = 0;
        drive(1'b0, 1'b0, 1'b1);
        exp = sb.pop_front(); got = sample(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL gapped_clear: got %h expected %h", got, exp);
        end
        for (int k = 0; k < 80; k++) begin
            if (k % 2 == 0) begin
                drive(1'b1, stream_bits[(k / 2) % 15], 1'b0);
                nvalid++;
            end else begin
                drive(1'b0, 1'($urandom_range(1)), 1'b0);
            end
            exp = sb.pop_front(); got = sample(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL gapped_stream cycle %0d: got %h expected %h", k, got, exp);
            end
            if (lock_at < 0 && got.locked) lock_at = nvalid;
        end
        vectors++;
        if (lock_at != 12 || got.err !== 16'd0 || got.bits !== 16'd28) begin
            miscompares++;
            $display("[TB] FAIL gapped_result: lock %0d err %0d bits %0d, expected 12/0/28",
                     lock_at, got.err, got.bits);
        end
    endtask

    task automatic test_single_error();
        int pulses  = 0;
        int dropped = 0;
        drive(1'b0, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, stream_bits[i % 15] ^ (i == 20), 1'b0);
            exp = sb.pop_front(); got = sample(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL single_err bit %0d: got %h expected %h", i, got, exp);
            end
            if (got.pulse) pulses++;
            if (i >= 11 && !got.locked) dropped++;
        end
        vectors++;
        if (pulses != 1 || dropped != 0 || got.err !== 16'd1 || got.bits !== 16'd28) begin
            miscompares++;
            $display("[TB] FAIL single_err_summary: pulses %0d drops %0d err %0d bits %0d, expected 1/0/1/28",
                     pulses, dropped, got.err, got.bits);
        end
    endtask

    task automatic test_back_to_back();
        int relock_at = -1;
        drive(1'b0, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, stream_bits[i % 15] ^ (i >= 20 && i <= 23), 1'b0);
            exp = sb.pop_front(); got = sample(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL burst bit %0d: got %h expected %h", i, got, exp);
            end
            if (i == 22) begin
                vectors++;
                if (got.locked !== 1'b1 || got.pulse !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL burst_third: locked %b pulse %b, expected 1 1", got.locked, got.pulse);
                end
            end
            if (i == 23) begin
                vectors++;
                if (got.locked !== 1'b0 || got.err !== 16'd4 || got.bits !== 16'd12) begin
                    miscompares++;
                    $display("[TB] FAIL burst_loss: locked %b err %0d bits %0d, expected 0/4/12",
                             got.locked, got.err, got.bits);
                end
            end
            if (i > 23 && relock_at < 0 && got.locked) relock_at = i - 23;
        end
        vectors++;
        if (relock_at != 12 || got.err !== 16'd4 || got.bits !== 16'd16) begin
            miscompares++;
            $display("[TB] FAIL burst_relock: after %0d bits err %0d bits %0d, expected 12/4/16",
                     relock_at, got.err, got.bits);
        end
    endtask

    task automatic test_zero_stream();
        int seen_lock = 0;
        drive(1'b0, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 50; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            exp = sb.pop_front(); got = sample(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL zero_stream bit %0d: got %h expected %h", i, got, exp);
            end
            if (got.locked) seen_lock++;
        end
        vectors++;
        if (seen_lock != 0 || got.err !== 16'd0 || got.bits !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL zero_summary: locked cycles %0d err %0d bits %0d, expected 0/0/0",
                     seen_lock, got.err, got.bits);
        end
    endtask

    task automatic test_saturation_clear_reset();
        int lock_at = -1;
        drive(1'b0, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, stream_bits[i % 15], 1'b0);
            exp = sb.pop_front(); got = sample(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL sat_stream bit %0d: got %h expected %h", i, got, exp);
            end
        end
        vectors++;
        if (got.bits_s !== 4'd15 || got.bits !== 16'd18) begin
            miscompares++;
            $display("[TB] FAIL sat_value: small %0d wide %0d, expected 15 and 18", got.bits_s, got.bits);
        end
        drive(1'b1, 1'b1, 1'b1);
        exp = sb.pop_front(); got = sample(); vectors++;
        if (got !== obs_t'(0) || exp !== obs_t'(0)) begin
            miscompares++;
            $display("[TB] FAIL sat_clear: got %h expected 0", got);
        end
        for (int i = 30; i < 45; i++) begin
            drive(1'b1, stream_bits[i % 15], 1'b0);
            exp = sb.pop_front(); got = sample(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL sat_relock bit %0d: got %h expected %h", i, got, exp);
            end
            if (lock_at < 0 && got.locked) lock_at = i - 29;
        end
        vectors++;
        if (lock_at != 12) begin
            miscompares++;
            $display("[TB] FAIL sat_relock_point: locked after %0d bits, expected 12", lock_at);
        end
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        got = sample();
        vectors++;
        if (got !== obs_t'(0)) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got %h expected 0", got);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        exp = sb.pop_front(); got = sample(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL post_reset: got %h expected %h", got, exp);
        end
    endtask

    initial begin
        $display("[TB] lfsr_checker bench start");
        test_reset();
        test_lock_clean();
        test_gapped();
        test_single_error();
        test_back_to_back();
        test_zero_stream();
        test_saturation_clear_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
